// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for the 5-stage MIPS core.
//
// The unit looks for three kinds of trouble and steers the pipeline around
// them:
//   - load-use hazards, which stall the front end for LOAD_STALL cycles;
//   - data-memory waits, which freeze the whole pipeline;
//   - taken branches and jumps, which flush the front end.
// It also counts the cycles in which the PC was held, for performance
// measurement.
//
// Parameters
//   REG_W       register-specifier width
//   LOAD_STALL  stall cycles per load-use hazard (>= 1)
//   CNT_W       width of the stall-cycle counter
//
// Ports
//   clk, rst            rising-edge clock; asynchronous active-high reset
//   id_rs, id_rt        source registers of the instruction in ID
//   id_use_rs/rt        the ID instruction really reads rs / rt
//   ex_mem_read, ex_rt  the EX instruction is a load, and its destination
//   ex_branch_taken     a taken branch or jump has been resolved in EX
//   mem_req, mem_ready  MEM-stage data access request and its completion
//   cnt_clr             synchronous clear of stall_count
//   pc_write            PC update enable
//   ifid_write          IF/ID register enable
//   ifid_flush          IF/ID register loads a NOP
//   idex_bubble         ID/EX register loads a NOP (control zeroed)
//   exmem_write         EX/MEM register enable
//   memwb_bubble        MEM/WB register loads a NOP
//   stall_count         saturating count of cycles with pc_write low
//   busy                high while a multi-cycle load-use stall is running
// ---------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int REG_W      = 5,
   parameter int LOAD_STALL = 1,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             cnt_clr,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             exmem_write,
   output logic             memwb_bubble,
   output logic [CNT_W-1:0] stall_count,
   output logic             busy
);

   // The down-counter only has to hold LOAD_STALL-1. It is kept at least
   // one bit wide so that the LOAD_STALL=1 build still elaborates.
   localparam int CW = (LOAD_STALL > 1) ? $clog2(LOAD_STALL) : 1;
   localparam logic [CW-1:0] CNT_START = CW'(LOAD_STALL - 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(1);

   typedef enum logic {
      IDLE,
      LSTALL
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;

   logic freeze;
   logic lu_hit;
   logic lu_stall;

   // The hazard terms are purely combinational, so the pipeline reacts in
   // the same cycle the offending instructions show up.
   //
   // A freeze means the data memory is still busy.
   //
   // A load into $zero never creates a dependency. A register match only
   // counts when the ID instruction really reads that source.
   //
   // Once the FSM sits in LSTALL, it keeps stalling whatever the ID stage
   // now holds.
   assign freeze   = mem_req & ~mem_ready;
   assign lu_hit   = ex_mem_read & (ex_rt != '0) &
                     ((id_use_rs & (ex_rt == id_rs)) |
                      (id_use_rt & (ex_rt == id_rt)));
   assign lu_stall = lu_hit | (state == LSTALL);

   // Per-stage controls, highest priority first:
   //   - reset: quiets the whole pipeline;
   //   - freeze: holds every stage and feeds bubbles into WB;
   //   - branch: squashes the wrong-path instructions in IF and ID;
   //   - load-use stall: holds PC and IF/ID and injects a bubble into EX.
   // Reset is included here so that the outputs follow rst asynchronously,
   // without waiting for a clock edge.
   always_comb begin
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      exmem_write  = 1'b1;
      memwb_bubble = 1'b0;
      if (rst) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         ifid_flush   = 1'b1;
         idex_bubble  = 1'b1;
         exmem_write  = 1'b0;
         memwb_bubble = 1'b1;
      end else if (freeze) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         exmem_write  = 1'b0;
         memwb_bubble = 1'b1;
      end else if (ex_branch_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (lu_stall) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
      end
   end

   // The stall FSM only moves in unfrozen cycles, so a memory wait simply
   // stretches a load-use stall.
   //
   // A taken branch aborts a stall in progress, because the stalled ID
   // instruction is being squashed anyway.
   //
   // The first stall cycle is spent in IDLE. LSTALL therefore covers the
   // remaining LOAD_STALL-1 cycles and is left on the cycle cnt reaches 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (!freeze) begin
         if (ex_branch_taken) begin
            state <= IDLE;
            cnt   <= '0;
         end else if (state == IDLE) begin
            if (lu_hit && (LOAD_STALL > 1)) begin
               state <= LSTALL;
               cnt   <= CNT_START;
            end
         end else begin
            if (cnt == CNT_LAST) begin
               state <= IDLE;
               cnt   <= '0;
            end else begin
               cnt <= cnt - CNT_LAST;
            end
         end
      end
   end

   // The performance counter counts every held-PC cycle, whether it comes
   // from a freeze or from a load-use stall. It sticks at all-ones instead
   // of wrapping. A clear wins over an increment in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_count <= '0;
      end else if (cnt_clr) begin
         stall_count <= '0;
      end else if (!pc_write && (stall_count != '1)) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end

   assign busy = (state == LSTALL);

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Testbench for hazard_ctrl. Three instances share one set of inputs:
//   - dutA: LOAD_STALL=1, CNT_W=16
//   - dutB: LOAD_STALL=3, CNT_W=16
//   - dutC: LOAD_STALL=3, CNT_W=4 (exercises counter saturation)
//
// A behavioural model tracks, for each instance, how many stall cycles are
// still owed and the expected counter value. Every falling edge, the
// outputs of all three instances are compared against that model.
// Directed scenarios add literal expectations of their own.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

   typedef struct packed {
      logic       r;
      logic       mr;
      logic [4:0] ert;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urs;
      logic       urt;
      logic       br;
      logic       mq;
      logic       mrdy;
      logic       clr;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_use_rs, id_use_rt, ex_mem_read, ex_branch_taken;
   logic       mem_req, mem_ready, cnt_clr;

   logic [5:0]  outs [3];
   logic        bsy  [3];
   logic [15:0] scnt [3];

   logic        a_pc, a_ifw, a_fl, a_bub, a_exw, a_wbb, a_busy;
   logic        b_pc, b_ifw, b_fl, b_bub, b_exw, b_wbb, b_busy;
   logic        c_pc, c_ifw, c_fl, c_bub, c_exw, c_wbb, c_busy;
   logic [15:0] a_cnt, b_cnt;
   logic [3:0]  c_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_W(5), .LOAD_STALL(1), .CNT_W(16)) dutA (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
      .mem_ready(mem_ready), .cnt_clr(cnt_clr),
      .pc_write(a_pc), .ifid_write(a_ifw), .ifid_flush(a_fl),
      .idex_bubble(a_bub), .exmem_write(a_exw), .memwb_bubble(a_wbb),
      .stall_count(a_cnt), .busy(a_busy));

   hazard_ctrl #(.REG_W(5), .LOAD_STALL(3), .CNT_W(16)) dutB (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
      .mem_ready(mem_ready), .cnt_clr(cnt_clr),
      .pc_write(b_pc), .ifid_write(b_ifw), .ifid_flush(b_fl),
      .idex_bubble(b_bub), .exmem_write(b_exw), .memwb_bubble(b_wbb),
      .stall_count(b_cnt), .busy(b_busy));

   hazard_ctrl #(.REG_W(5), .LOAD_STALL(3), .CNT_W(4)) dutC (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
      .mem_ready(mem_ready), .cnt_clr(cnt_clr),
      .pc_write(c_pc), .ifid_write(c_ifw), .ifid_flush(c_fl),
      .idex_bubble(c_bub), .exmem_write(c_exw), .memwb_bubble(c_wbb),
      .stall_count(c_cnt), .busy(c_busy));

   // Gather each instance's outputs into arrays so that one compare loop
   // can serve all three. Bit order is {pc, ifid_w, flush, bubble, exmem_w,
   // wb_bubble}.
   assign outs[0] = {a_pc, a_ifw, a_fl, a_bub, a_exw, a_wbb};
   assign outs[1] = {b_pc, b_ifw, b_fl, b_bub, b_exw, b_wbb};
   assign outs[2] = {c_pc, c_ifw, c_fl, c_bub, c_exw, c_wbb};
   assign bsy[0]  = a_busy;
   assign bsy[1]  = b_busy;
   assign bsy[2]  = c_busy;
   assign scnt[0] = a_cnt;
   assign scnt[1] = b_cnt;
   assign scnt[2] = {12'd0, c_cnt};

   // Model state per instance:
   //   - owed: stall cycles still to come after the current one;
   //   - mcnt: the expected stall_count.
   int ls    [3] = '{1, 3, 3};
   int cmax  [3] = '{65535, 65535, 15};
   int owed  [3] = '{0, 0, 0};
   int mcnt  [3] = '{0, 0, 0};

   // Compare process: on every falling edge, work out from the rules what
   // each instance must show, compare, then advance the model to the state
   // it will have after the next rising edge.
   always @(negedge clk) begin
      logic       frz, hit;
      logic [5:0] ev;
      logic       eb;
      frz = mem_req && !mem_ready;
      hit = ex_mem_read && (ex_rt != 5'd0) &&
            ((id_use_rs && ex_rt == id_rs) || (id_use_rt && ex_rt == id_rt));
      for (int k = 0; k < 3; k++) begin
         eb = 1'b0;
         if (rst) begin
            owed[k] = 0;
            mcnt[k] = 0;
            ev = 6'b000110 | 6'b000001;
            ev = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
         end else begin
            eb = (owed[k] > 0);
            if (frz) begin
               ev = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            end else if (ex_branch_taken) begin
               ev = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            end else if (owed[k] > 0 || hit) begin
               ev = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
            end else begin
               ev = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
            end
         end
         checks++;
         if (outs[k] !== ev) begin
            errors++;
            $display("[TB] FAIL model_ctrl dut%0d t=%0t: got %b expected %b",
                     k, $time, outs[k], ev);
         end
         checks++;
         if (bsy[k] !== eb) begin
            errors++;
            $display("[TB] FAIL model_busy dut%0d t=%0t: got %b expected %b",
                     k, $time, bsy[k], eb);
         end
         checks++;
         if (scnt[k] !== 16'(mcnt[k])) begin
            errors++;
            $display("[TB] FAIL model_count dut%0d t=%0t: got %0d expected %0d",
                     k, $time, scnt[k], mcnt[k]);
         end
         if (!rst) begin
            if (!frz) begin
               if (ex_branch_taken) owed[k] = 0;
               else if (owed[k] > 0) owed[k] = owed[k] - 1;
               else if (hit) owed[k] = ls[k] - 1;
            end
            if (cnt_clr) mcnt[k] = 0;
            else if (!ev[5] && mcnt[k] < cmax[k]) mcnt[k] = mcnt[k] + 1;
         end
      end
   end

   // Watchdog so the run always ends, even if the stimulus stalls.
   initial begin
      #20000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s t=%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Drive one vector for a whole cycle: apply it just after a rising edge,
   // then return just after the falling edge, where the outputs are stable.
   task automatic applyStimulus(input vec_t v);
      @(posedge clk);
      #1;
      rst             = v.r;
      ex_mem_read     = v.mr;
      ex_rt           = v.ert;
      id_rs           = v.rs;
      id_rt           = v.rt;
      id_use_rs       = v.urs;
      id_use_rt       = v.urt;
      ex_branch_taken = v.br;
      mem_req         = v.mq;
      mem_ready       = v.mrdy;
      cnt_clr         = v.clr;
      @(negedge clk);
      #1;
   endtask

   function automatic vec_t idleV();
      vec_t v;
      v = '0;
      v.rs = 5'd3;
      v.rt = 5'd4;
      return v;
   endfunction

   // Load into $8 followed by an instruction reading $8 through rs.
   function automatic vec_t hazV();
      vec_t v;
      v = idleV();
      v.mr  = 1'b1;
      v.ert = 5'd8;
      v.rs  = 5'd8;
      v.urs = 1'b1;
      return v;
   endfunction

   function automatic vec_t frzV();
      vec_t v;
      v = idleV();
      v.mq = 1'b1;
      return v;
   endfunction

   // Directed scenarios.
   initial begin
      vec_t v;
      rst = 1'b1;
      ex_mem_read = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0;
      id_use_rs = 1'b0; id_use_rt = 1'b0; ex_branch_taken = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b0; cnt_clr = 1'b0;

      // Values while reset is held.
      #2;
      checkOutput("rst_pc_write", b_pc, 0);
      checkOutput("rst_exmem_write", b_exw, 0);
      checkOutput("rst_ifid_flush", b_fl, 1);
      checkOutput("rst_memwb_bubble", b_wbb, 1);
      checkOutput("rst_busy", b_busy, 0);
      checkOutput("rst_count", b_cnt, 0);
      v = idleV(); v.r = 1'b1;
      applyStimulus(v);
      applyStimulus(idleV());
      checkOutput("idle_pc_write", b_pc, 1);

      // A single load-use hazard.
      applyStimulus(hazV());
      checkOutput("lu1_pc_write", a_pc, 0);
      checkOutput("lu1_ifid_write", a_ifw, 0);
      checkOutput("lu1_idex_bubble", a_bub, 1);
      checkOutput("lu3_c1_pc_write", b_pc, 0);
      checkOutput("lu3_c1_busy", b_busy, 0);
      applyStimulus(idleV());
      checkOutput("lu1_after_pc_write", a_pc, 1);
      checkOutput("lu1_count", a_cnt, 1);
      checkOutput("lu3_c2_pc_write", b_pc, 0);
      checkOutput("lu3_c2_busy", b_busy, 1);
      applyStimulus(idleV());
      checkOutput("lu3_c3_pc_write", b_pc, 0);
      checkOutput("lu3_c3_busy", b_busy, 1);
      applyStimulus(idleV());
      checkOutput("lu3_done_pc_write", b_pc, 1);
      checkOutput("lu3_done_busy", b_busy, 0);
      checkOutput("lu3_count", b_cnt, 3);
      v = idleV(); v.clr = 1'b1;
      applyStimulus(v);
      applyStimulus(idleV());
      checkOutput("clr_count", b_cnt, 0);

      // Loads that must not stall.
      v = hazV(); v.ert = 5'd0; v.rs = 5'd0;
      applyStimulus(v);
      checkOutput("r0_pc_write", b_pc, 1);
      v = idleV(); v.mr = 1'b1; v.ert = 5'd5; v.rt = 5'd5; v.urt = 1'b0; v.urs = 1'b1;
      applyStimulus(v);
      checkOutput("nouse_pc_write", a_pc, 1);
      applyStimulus(idleV());
      checkOutput("nostall_count", b_cnt, 0);

      // Load-use stall stretched by a four-cycle memory wait.
      applyStimulus(hazV());
      applyStimulus(frzV());
      checkOutput("frz_exmem_write", b_exw, 0);
      checkOutput("frz_memwb_bubble", b_wbb, 1);
      checkOutput("frz_idex_bubble", b_bub, 0);
      checkOutput("frz_busy", b_busy, 1);
      applyStimulus(frzV());
      applyStimulus(frzV());
      applyStimulus(frzV());
      v = idleV(); v.mq = 1'b1; v.mrdy = 1'b1;
      applyStimulus(v);
      checkOutput("frz_release_exmem_write", b_exw, 1);
      checkOutput("frz_release_pc_write", b_pc, 0);
      applyStimulus(idleV());
      checkOutput("frz_last_pc_write", b_pc, 0);
      applyStimulus(idleV());
      checkOutput("frz_done_pc_write", b_pc, 1);
      checkOutput("frz_count_ls3", b_cnt, 7);
      checkOutput("frz_count_ls1", a_cnt, 5);
      v = idleV(); v.clr = 1'b1;
      applyStimulus(v);

      // Branch together with a load-use hit on rt: the flush wins.
      v = idleV(); v.mr = 1'b1; v.ert = 5'd5; v.rt = 5'd5; v.urt = 1'b1; v.br = 1'b1;
      applyStimulus(v);
      checkOutput("br_hit_flush", b_fl, 1);
      checkOutput("br_hit_bubble", b_bub, 1);
      checkOutput("br_hit_pc_write", b_pc, 1);
      applyStimulus(idleV());
      checkOutput("br_hit_after_busy", b_busy, 0);

      // A branch arriving during LSTALL aborts the stall.
      applyStimulus(hazV());
      v = idleV(); v.br = 1'b1;
      applyStimulus(v);
      checkOutput("br_lstall_flush", b_fl, 1);
      checkOutput("br_lstall_pc_write", b_pc, 1);
      applyStimulus(idleV());
      checkOutput("br_lstall_after_busy", b_busy, 0);
      checkOutput("br_lstall_after_pc", b_pc, 1);

      // A branch during a freeze waits for the first unfrozen cycle.
      v = frzV(); v.br = 1'b1;
      applyStimulus(v);
      checkOutput("br_frz_flush", b_fl, 0);
      v = idleV(); v.br = 1'b1;
      applyStimulus(v);
      checkOutput("br_frz_deferred_flush", b_fl, 1);

      // Reset asserted in the middle of LSTALL.
      applyStimulus(hazV());
      applyStimulus(idleV());
      checkOutput("pre_rst_busy", b_busy, 1);
      rst = 1'b1;
      #1;
      checkOutput("arst_pc_write", b_pc, 0);
      checkOutput("arst_ifid_flush", b_fl, 1);
      checkOutput("arst_idex_bubble", b_bub, 1);
      checkOutput("arst_busy", b_busy, 0);
      checkOutput("arst_count", b_cnt, 0);
      v = idleV(); v.r = 1'b1;
      applyStimulus(v);
      applyStimulus(idleV());
      checkOutput("post_rst_busy", b_busy, 0);
      checkOutput("post_rst_pc_write", b_pc, 1);
      checkOutput("post_rst_count", b_cnt, 0);

      // Saturate the 4-bit counter, then clear it.
      for (int i = 0; i < 17; i++) applyStimulus(frzV());
      applyStimulus(idleV());
      checkOutput("sat_count_w4", c_cnt, 15);
      checkOutput("sat_count_w16", b_cnt, 17);
      v = idleV(); v.clr = 1'b1;
      applyStimulus(v);
      applyStimulus(idleV());
      checkOutput("sat_clr_count", c_cnt, 0);

      @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage MIPS core, replacing the single-cycle load-use stall logic. Detects load-use hazards with a configurable multi-cycle stall length and a register-zero exemption. Freezes the whole pipeline while a data-memory access is not ready and flushes the front end on taken branches and jumps. Drives per-stage write enables and bubble/flush controls, and keeps a saturating stall-cycle counter for performance measurement.

## Interface
- REG_W, 5, register-specifier width
- LOAD_STALL, 1, stall cycles per load-use hazard (≥1)
- CNT_W, 16, width of stall-cycle counter
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- id_rs, id_rt  in  REG_W  source registers of instruction in ID
- id_use_rs, id_use_rt  in  1  ID instruction actually reads rs / rt
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  REG_W  load destination in EX
- ex_branch_taken  in  1  taken branch or jump resolved in EX
- mem_req  in  1  MEM stage has an active data-memory access
- mem_ready  in  1  data memory completes access this cycle
- cnt_clr  in  1  synchronous clear of stall_count
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID loads NOP
- idex_bubble  out  1  ID/EX loads NOP (control zeroed)
- exmem_write  out  1  EX/MEM register enable
- memwb_bubble  out  1  MEM/WB loads NOP
- stall_count  out  CNT_W  cycles with pc_write=0 since reset/clear, saturating
- busy  out  1  state ≠ IDLE

## Operation
- Hazard terms, all combinational:
  - freeze = mem_req & ~mem_ready
  - lu_hit = ex_mem_read & (ex_rt≠0) & ((id_use_rs & ex_rt==id_rs) | (id_use_rt & ex_rt==id_rt))
- Priority: freeze > ex_branch_taken > load-use (lu_hit or LSTALL).
- FSM states:
  - IDLE: normal operation.
  - LSTALL: load-use stall continuing, with down-counter cnt.
- Freeze (any state):
  - pc_write=ifid_write=exmem_write=0, memwb_bubble=1, ifid_flush=idex_bubble=0.
  - ID/EX holds its contents.
  - FSM state and cnt hold.
- Branch (no freeze):
  - ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1, exmem_write=1.
  - LSTALL aborts to IDLE.
- Load-use, IDLE & lu_hit (no freeze, no branch):
  - pc_write=ifid_write=0, idex_bubble=1, exmem_write=1.
  - If LOAD_STALL>1: go to LSTALL, cnt←LOAD_STALL-1; otherwise stay IDLE.
- LSTALL (no freeze, no branch):
  - Same outputs as load-use, independent of lu_hit.
  - cnt decrements each cycle; leave to IDLE on the cycle cnt==1.
- Otherwise: all enables 1, all flush/bubble 0.
- stall_count:
  - +1 on every non-reset cycle with pc_write=0; saturates at all-ones.
  - cnt_clr clears it and takes priority over increment.

## Timing
- rst asserted, asynchronously and for the whole reset period:
  - state=IDLE, cnt=0, stall_count=0.
  - pc_write=ifid_write=exmem_write=0; ifid_flush=idex_bubble=memwb_bubble=1; busy=0.
- Detection is zero-latency: outputs respond in the same cycle inputs change.
- A load-use hazard stalls exactly LOAD_STALL cycles, plus any freeze cycles that overlap it.
- Freeze lasts exactly while mem_req & ~mem_ready. The cycle mem_ready rises is a normal cycle.
- Branch flush lasts one cycle per cycle ex_branch_taken is high outside freeze.
- A branch during freeze is deferred: EX holds, so it is applied in the first unfrozen cycle.
- Reset during LSTALL or freeze returns to the reset values immediately. The first cycle after release is IDLE.
- ex_rt==0 never stalls. Neither does a match on a source with use=0.

## Test plan
- LOAD_STALL=1; ex_mem_read=1, ex_rt=8, id_rs=8, id_use_rs=1 for 1 cycle -> pc_write=ifid_write=0, idex_bubble=1 for 1 cycle, stall_count=1.
- LOAD_STALL=3; same hazard, then ex_mem_read=0 -> stall for 3 consecutive cycles, busy=1 for cycles 2-3, then normal; stall_count=3.
- ex_rt=0 matching id_rs; also ex_rt=5=id_rt with id_use_rt=0 -> no stall, stall_count unchanged.
- LOAD_STALL=3; in the 2nd stall cycle hold mem_req=1, mem_ready=0 for 4 cycles -> exmem_write=0, memwb_bubble=1, cnt holds; total stalled cycles=7; stall_count=7.
- lu_hit and ex_branch_taken together -> ifid_flush=idex_bubble=1, pc_write=1, no stall; branch raised during LSTALL -> immediate flush, return to IDLE.
- Assert rst mid-LSTALL -> outputs take reset values asynchronously; after release the unit is IDLE, stall_count=0; cnt_clr with saturated counter (CNT_W=4, 15) -> 0 next cycle.
